// File: rtl/arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : arb_pkg                                                |
// | Description : Shared types for the instruction/data memory port      |
// |               arbiter: FSM state and transaction owner encodings.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

endpackage
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : arb_pick                                               |
// | Description : Combinational winner select. Data side has fixed       |
// |               priority unless the fetch side has been starved long   |
// |               enough, in which case fetch is forced through.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module arb_pick
    import arb_pkg::*;
(
    input  logic       fetch_req_i,
    input  logic       data_req_i,
    input  logic       force_fetch_i,
    output logic       valid_o,
    output arb_owner_t winner_o
);

    // D wins unless I is pending and its wait budget is exhausted
    always_comb begin
        valid_o  = fetch_req_i | data_req_i;
        winner_o = (data_req_i && !(fetch_req_i && force_fetch_i)) ? OWN_D : OWN_I;
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                       |
// | Description : Shares one single-ported memory between instruction    |
// |               fetch (I) and load/store (D). One transaction in       |
// |               flight; response routed back to the owner.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            m_req,
    output logic            m_we,
    output logic [DW/8-1:0] m_be,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic            m_gnt,
    input  logic            m_rvalid,
    input  logic [DW-1:0]   m_rdata,
    output logic            busy,
    output logic            err
);

    localparam int            BW         = DW / 8;
    localparam int            CW         = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] C_MAX_WAIT = CW'(MAX_WAIT);

    arb_state_t      state_q;
    arb_owner_t      owner_q;
    logic [CW-1:0]   wait_cnt_q;
    logic [CW-1:0]   wait_cnt_d;
    logic            m_req_q;
    logic            m_we_q;
    logic [BW-1:0]   m_be_q;
    logic [AW-1:0]   m_addr_q;
    logic [DW-1:0]   m_wdata_q;
    logic            err_q;
    logic            err_d;

    logic            w_pick_valid;
    arb_owner_t      w_winner;
    logic            w_accept;
    logic            w_resp;

    arb_pick u_pick (
        .fetch_req_i   (i_req),
        .data_req_i    (d_req),
        .force_fetch_i (wait_cnt_q == C_MAX_WAIT),
        .valid_o       (w_pick_valid),
        .winner_o      (w_winner)
    );

    // memory accepted the command / a response belongs to the current owner
    assign w_accept = (state_q == ARB_REQ) && m_gnt;
    assign w_resp   = (w_accept && m_rvalid) || ((state_q == ARB_WAIT) && m_rvalid);

    assign i_gnt    = w_accept && (owner_q == OWN_I);
    assign d_gnt    = w_accept && (owner_q == OWN_D);
    assign i_rvalid = w_resp && (owner_q == OWN_I);
    assign d_rvalid = w_resp && (owner_q == OWN_D);
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_be     = m_be_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign busy     = (state_q != ARB_IDLE);
    assign err      = err_q;

    // starvation counter: counts D wins over a pending I, cleared when I wins
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if ((state_q == ARB_IDLE) && w_pick_valid) begin
            if (w_winner == OWN_I) begin
                wait_cnt_d = '0;
            end else if (i_req && (wait_cnt_q != C_MAX_WAIT)) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
    end

    // a response that cannot be routed to an owner is a protocol error
    always_comb begin
        err_d = err_q | (m_rvalid & ~w_resp);
    end

    // transaction FSM with registered memory command
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_I;
            wait_cnt_q <= '0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_be_q     <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
            case (state_q)
                ARB_IDLE: begin
                    if (w_pick_valid) begin
                        owner_q <= w_winner;
                        m_req_q <= 1'b1;
                        state_q <= ARB_REQ;
                        if (w_winner == OWN_D) begin
                            m_we_q    <= d_we;
                            m_be_q    <= d_be;
                            m_addr_q  <= d_addr;
                            m_wdata_q <= d_wdata;
                        end else begin
                            m_we_q    <= 1'b0;
                            m_be_q    <= '1;
                            m_addr_q  <= i_addr;
                            m_wdata_q <= '0;
                        end
                    end
                end
                ARB_REQ: begin
                    if (m_gnt) begin
                        m_req_q <= 1'b0;
                        state_q <= m_rvalid ? ARB_IDLE : ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (m_rvalid) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: begin
                    m_req_q <= 1'b0;
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
